// File: rtl/dec16_timer_pkg.sv
// Shared constants and state type for the dec16 down-counting timer.
package dec16_timer_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/dec16_bit.sv
// Combinational ripple-borrow decrementer: y = a - 1, borrow_out set when a == 0.
module dec16_bit #(
  parameter int unsigned WIDTH = dec16_timer_pkg::DefaultWidth
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             borrow_out
);

  always_comb begin
    logic borrow;
    borrow = 1'b1;
    y      = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      y[i]   = a[i] ^ borrow;
      borrow = ~a[i] & borrow;
    end
    borrow_out = borrow;
  end

endmodule

// File: rtl/dec16_timer.sv
// Loadable down-counter with one-shot/periodic modes, pause, abort and a
// registered terminal-count strobe.
module dec16_timer
  import dec16_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] count_dec;
  logic             unused_borrow;

  dec16_bit #(
    .WIDTH(WIDTH)
  ) u_dec (
    .a         (count_q),
    .y         (count_dec),
    .borrow_out(unused_borrow)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // abort has no meaning here; a load is accepted regardless
        if (load_valid) begin
          count_d  = load_value;
          reload_d = load_value;
          mode_d   = auto_reload;
          if (load_value != '0) begin
            state_d = StRun;
          end else begin
            tc_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          count_d = '0;
          state_d = StIdle;
        end else if (enable) begin
          if (count_q == WIDTH'(1)) begin
            tc_d = 1'b1;
            if (mode_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = StIdle;
            end
          end else begin
            count_d = count_dec;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign count      = count_q;
  assign tc_pulse   = tc_q;
  assign busy       = (state_q == StRun);
  assign load_ready = (state_q == StIdle);

endmodule
